// File: rtl/cdc_tx_scheduler.sv
// Round-robin scheduler that serialises NUM_REQ requesters onto one word bus feeding a
// destination-domain data synchronizer. Each word is qualified by tx_enable_o for
// HOLD_CYCLES cycles, followed by GAP_CYCLES low cycles so the far side sees a clean edge.
// HOLD_CYCLES and GAP_CYCLES must each cover (synchronizer stages + 1) destination clocks.
module cdc_tx_scheduler #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [BUS_WIDTH-1:0]           tx_bus_o,
    output logic                           tx_enable_o,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id_o,
    output logic                           busy_o
);

    localparam int unsigned IdW    = $clog2(NUM_REQ);
    localparam int unsigned MaxCyc = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StGap
    } state_e;

    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [IdW-1:0]         rr_ptr_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [BUS_WIDTH-1:0]   tx_bus_q;
    logic                   tx_enable_q;
    logic [IdW-1:0]         grant_id_q;
    logic                   busy_q;

    logic [BUS_WIDTH-1:0]   data_arr [NUM_REQ];
    logic                   sel_found;
    logic [IdW-1:0]         sel_idx;
    logic [IdW-1:0]         cand;
    logic [IdW:0]           sum;
    logic [IdW-1:0]         rr_ptr_nxt;

    // Split the flat data bus into one word per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data_i[i*BUS_WIDTH +: BUS_WIDTH];
    end

    // First asserted request at or above rr_ptr_q, wrapping past NUM_REQ-1.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IdW + 1)'(k);
            if (sum >= (IdW + 1)'(NUM_REQ)) begin
                sum = sum - (IdW + 1)'(NUM_REQ);
            end
            cand = sum[IdW-1:0];
            if (!sel_found && req_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority next round.
    always_comb begin
        rr_ptr_nxt = (sel_idx == IdW'(NUM_REQ - 1)) ? '0 : sel_idx + IdW'(1);
    end

    // Scheduler FSM; every output comes straight from a register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            ack_q       <= '0;
            tx_bus_q    <= '0;
            tx_enable_q <= 1'b0;
            grant_id_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                StIdle: begin
                    if (sel_found) begin
                        tx_bus_q       <= data_arr[sel_idx];
                        tx_enable_q    <= 1'b1;
                        ack_q[sel_idx] <= 1'b1;
                        grant_id_q     <= sel_idx;
                        rr_ptr_q       <= rr_ptr_nxt;
                        cnt_q          <= CntW'(HOLD_CYCLES - 1);
                        busy_q         <= 1'b1;
                        state_q        <= StHold;
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        tx_enable_q <= 1'b0;
                        cnt_q       <= CntW'(GAP_CYCLES - 1);
                        state_q     <= StGap;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign tx_bus_o    = tx_bus_q;
    assign tx_enable_o = tx_enable_q;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Scoreboard bench for cdc_tx_scheduler: stimulus pushes expected grants, a negedge
// monitor pops one entry per ack pulse; timing/reset checks are made inline.
module tb_cdc_tx_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [3:0]  req_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  ack_o;
    logic [7:0]  tx_bus_o;
    logic        tx_enable_o;
    logic [1:0]  grant_id_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [3:0] ack;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    cdc_tx_scheduler #(
        .BUS_WIDTH  (8),
        .NUM_REQ    (4),
        .HOLD_CYCLES(4),
        .GAP_CYCLES (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .ack_o      (ack_o),
        .tx_bus_o   (tx_bus_o),
        .tx_enable_o(tx_enable_o),
        .grant_id_o (grant_id_o),
        .busy_o     (busy_o)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_grant(input int id, input logic [7:0] d);
        exp_t e;
        e.ack  = 4'b0001 << id;
        e.id   = 2'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        RST = 1'b1;
    endtask

    // Waits (bounded) for the next ack pulse and returns the cycle it appeared in.
    task automatic wait_ack(input string name, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_o !== 4'b0000) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: no ack within 20 cycles, got none expected ack", name);
    endtask

    task automatic idle_wait(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: every ack pulse must match the oldest outstanding expected grant.
    always @(negedge CLK) begin
        exp_t e;
        if (ack_o !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack %b id %0d bus %0h expected no ack",
                         ack_o, grant_id_o, tx_bus_o);
            end else begin
                e = exp_q.pop_front();
                chk("grant_ack", 32'(ack_o), 32'(e.ack));
                chk("grant_id", 32'(grant_id_o), 32'(e.id));
                chk("grant_data", 32'(tx_bus_o), 32'(e.data));
            end
        end
    end

    initial begin
        int t[5];
        int at;

        // Reset values while RST is held low.
        tick();
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_tx_bus", 32'(tx_bus_o), 32'h0);
        chk("rst_tx_enable", 32'(tx_enable_o), 32'h0);
        chk("rst_grant_id", 32'(grant_id_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        RST = 1'b1;
        tick();

        // Single request: enable high cycles 1-4, low 5-8, idle at 9.
        req_i = 4'b0001;
        req_data_i[7:0] = 8'hA5;
        expect_grant(0, 8'hA5);
        tick();
        chk("single_en_c1", 32'(tx_enable_o), 32'h1);
        chk("single_busy_c1", 32'(busy_o), 32'h1);
        req_i = 4'b0000;
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk($sformatf("single_en_c%0d", c), 32'(tx_enable_o), (c <= 4) ? 32'h1 : 32'h0);
        end
        chk("single_bus_retained", 32'(tx_bus_o), 32'hA5);
        chk("single_busy_c8", 32'(busy_o), 32'h1);
        tick();
        chk("single_busy_c9", 32'(busy_o), 32'h0);
        chk("single_en_c9", 32'(tx_enable_o), 32'h0);

        // Full contention from reset: 0,1,2,3,0 at 9-cycle spacing.
        do_reset();
        req_i = 4'b1111;
        req_data_i = 32'h44332211;
        expect_grant(0, 8'h11);
        expect_grant(1, 8'h22);
        expect_grant(2, 8'h33);
        expect_grant(3, 8'h44);
        expect_grant(0, 8'h11);
        for (int i = 0; i < 5; i++) begin
            wait_ack("contention", t[i]);
            if (i == 4) req_i = 4'b0000;
        end
        for (int i = 1; i < 5; i++) chk($sformatf("contention_period%0d", i), 32'(t[i] - t[i-1]), 32'd9);
        idle_wait(9);

        // Sparse round-robin: only 0 and 2 ever granted.
        do_reset();
        req_i = 4'b0101;
        req_data_i = 32'h00C3005A;
        expect_grant(0, 8'h5A);
        expect_grant(2, 8'hC3);
        expect_grant(0, 8'h5A);
        expect_grant(2, 8'hC3);
        for (int i = 0; i < 4; i++) begin
            wait_ack("sparse", t[i]);
            if (i == 3) req_i = 4'b0000;
        end
        for (int i = 1; i < 4; i++) chk($sformatf("sparse_period%0d", i), 32'(t[i] - t[i-1]), 32'd9);
        idle_wait(9);

        // Data stability: rr_ptr is 3, so requester 1 wins; its data churns afterwards.
        req_i = 4'b0010;
        req_data_i[15:8] = 8'h10;
        expect_grant(1, 8'h10);
        wait_ack("stable", at);
        req_i = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            req_data_i[15:8] = 8'hF0 + 8'(c);
            tick();
            chk($sformatf("stable_bus%0d", c), 32'(tx_bus_o), 32'h10);
        end
        req_i = 4'b0010;
        req_data_i[15:8] = 8'h77;
        expect_grant(1, 8'h77);
        wait_ack("stable_next", at);
        req_i = 4'b0000;
        idle_wait(9);

        // Mid-HOLD reset aborts the transfer; search restarts at index 0.
        req_i = 4'b0001;
        req_data_i[7:0] = 8'h99;
        expect_grant(0, 8'h99);
        wait_ack("midrst_first", at);
        req_i = 4'b0000;
        tick();
        RST = 1'b0;
        #1;
        chk("midrst_tx_enable", 32'(tx_enable_o), 32'h0);
        chk("midrst_tx_bus", 32'(tx_bus_o), 32'h0);
        chk("midrst_busy", 32'(busy_o), 32'h0);
        chk("midrst_grant_id", 32'(grant_id_o), 32'h0);
        tick();
        RST = 1'b1;
        req_i = 4'b1000;
        req_data_i[31:24] = 8'hE7;
        expect_grant(3, 8'hE7);
        wait_ack("midrst_after", at);
        req_i = 4'b0000;
        idle_wait(9);

        // Withdrawn request: req[1] raised in GAP and dropped before IDLE is never acked.
        req_i = 4'b0001;
        req_data_i[7:0] = 8'h3C;
        expect_grant(0, 8'h3C);
        wait_ack("withdraw_first", at);
        req_i = 4'b0000;
        idle_wait(5);
        req_i = 4'b0010;
        idle_wait(2);
        req_i = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("withdraw_busy%0d", i), 32'(busy_o), 32'h0);
            chk($sformatf("withdraw_ack%0d", i), 32'(ack_o), 32'h0);
        end

        idle_wait(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
